// File: rtl/ram_master.sv
// rtl/ram_master.sv - burst read/write initiator for the shared single-port synth RAM
//
// Accepts read/write burst requests over a valid/ready handshake and drives the
// RAM's registered Address/ReadWrite outputs and the shared bidirectional Data bus.
// One word moves per clock; a TURN cycle separates every burst so that Data
// ownership never overlaps between master and RAM.
//
// Ports:
//   Clock, Reset          clock and asynchronous active-low reset
//   ReqValid/ReqReady     request handshake; ReqReady high only when idle
//   ReqWrite              1 = write burst, 0 = read burst
//   ReqAddress            first word address (wraps modulo 2**ADDR_WIDTH)
//   ReqLength             burst length minus one
//   WrData/WrValid/WrReady  write word stream
//   RdData/RdValid        registered read word plus one-cycle strobe
//   Busy                  high outside IDLE
//   Address, ReadWrite    registered RAM control
//   Data                  shared bus, driven by the master only while ReadWrite=1
module ram_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddress,
    input  logic [LEN_WIDTH-1:0]  ReqLength,
    input  logic [DATA_WIDTH-1:0] WrData,
    input  logic                  WrValid,
    output logic                  WrReady,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  RdValid,
    output logic                  Busy,
    output logic [ADDR_WIDTH-1:0] Address,
    inout  wire  [DATA_WIDTH-1:0] Data,
    output logic                  ReadWrite
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_RD_LAST = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_TURN    = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH:0]    CNT_ONE  = (LEN_WIDTH + 1)'(1);

    logic [2:0]            state_q,   state_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;     // next address to issue
    logic [LEN_WIDTH:0]    cnt_q,     cnt_d;      // words still to issue
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  rw_q,      rw_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic                  rdvalid_q, rdvalid_d;
    logic                  cap_q,     cap_d;      // RAM is presenting a read word this cycle

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        address_d = address_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        // An address issued during RD is registered by the RAM one edge later,
        // so the word sits on Data the cycle after each RD cycle.
        cap_d     = (state_q == S_RD);
        rdvalid_d = cap_q;
        rdata_d   = cap_q ? Data : rdata_q;

        case (state_q)
            S_IDLE: begin
                rw_d = 1'b0;
                if (ReqValid) begin
                    address_d = ReqAddress;
                    if (ReqWrite) begin
                        addr_d  = ReqAddress;
                        cnt_d   = {1'b0, ReqLength} + CNT_ONE;
                        state_d = S_WR;
                    end else begin
                        // The first read address goes out with the accept itself.
                        addr_d  = ReqAddress + ADDR_ONE;
                        cnt_d   = {1'b0, ReqLength};
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == '0) begin
                    state_d = S_RD_LAST;
                end else begin
                    address_d = addr_q;
                    addr_d    = addr_q + ADDR_ONE;
                    cnt_d     = cnt_q - CNT_ONE;
                end
            end
            S_RD_LAST: begin
                state_d = S_TURN;
            end
            S_WR: begin
                if (cnt_q == '0) begin
                    // Last word was written on this edge; hand the bus back.
                    rw_d    = 1'b0;
                    state_d = S_TURN;
                end else if (WrValid) begin
                    address_d = addr_q;
                    wdata_d   = WrData;
                    rw_d      = 1'b1;
                    addr_d    = addr_q + ADDR_ONE;
                    cnt_d     = cnt_q - CNT_ONE;
                end
                // A stall holds Address/Data/ReadWrite; rewriting the same word is harmless.
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rw_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            address_q <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rdvalid_q <= 1'b0;
            cap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            address_q <= address_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rdvalid_q <= rdvalid_d;
            cap_q     <= cap_d;
        end
    end

    // Bus enable follows the registered ReadWrite, so reset releases Data at once.
    assign Data      = rw_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign ReqReady  = (state_q == S_IDLE);
    assign Busy      = (state_q != S_IDLE);
    assign WrReady   = (state_q == S_WR) && (cnt_q != '0);
    assign RdData    = rdata_q;
    assign RdValid   = rdvalid_q;
    assign Address   = address_q;
    assign ReadWrite = rw_q;

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - scoreboard bench for ram_master with a behavioural RAM
module tb_ram_master;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       ReqValid = 1'b0;
    logic       ReqReady;
    logic       ReqWrite = 1'b0;
    logic [7:0] ReqAddress = '0;
    logic [3:0] ReqLength = '0;
    logic [7:0] WrData = '0;
    logic       WrValid = 1'b0;
    logic       WrReady;
    logic [7:0] RdData;
    logic       RdValid;
    logic       Busy;
    logic [7:0] Address;
    wire  [7:0] Data;
    logic       ReadWrite;

    ram_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddress(ReqAddress), .ReqLength(ReqLength),
        .WrData(WrData), .WrValid(WrValid), .WrReady(WrReady),
        .RdData(RdData), .RdValid(RdValid), .Busy(Busy),
        .Address(Address), .Data(Data), .ReadWrite(ReadWrite)
    );

    always #5 Clock = ~Clock;

    // Behavioural single-port RAM: registered read, drives Data whenever ReadWrite=0.
    logic [7:0] mem [256];
    logic [7:0] rd_reg = '0;
    logic       ram_oe = 1'b1;
    always @(posedge Clock) begin
        if (ReadWrite) mem[Address] <= Data;
        else           rd_reg <= mem[Address];
    end
    assign Data = (!ReadWrite && ram_oe) ? rd_reg : 8'bz;

    // Reference memory contents; known=0 marks a word whose write may or may not have landed.
    logic [7:0] ref_mem [256];
    bit         known   [256];
    logic [7:0] wbuf    [16];

    typedef struct {
        logic [7:0] data;
        bit         care;
        int         cyc;
    } exp_t;
    exp_t sbq [$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int x_cnt = 0;
    int next_accept = 0;
    bit chain_valid = 1'b0;

    always @(posedge Clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every RdValid strobe must match the oldest expected word, on its exact cycle.
    always @(negedge Clock) begin
        if (Reset) begin
            if ($isunknown(Data)) x_cnt++;
            if (RdValid) begin
                if (sbq.size() == 0) begin
                    n_total++;
                    $display("FAIL rd_unexpected: RdValid with data %0h at cycle %0d, expected no read word", RdData, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (e.care) chk("rd_data", RdData, e.data);
                    chk("rd_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic request(input bit wr, input logic [7:0] a, input int n, output int e0);
        int guard = 0;
        ReqWrite = wr; ReqAddress = a; ReqLength = 4'(n - 1); ReqValid = 1'b1;
        while (!ReqReady && guard < 200) begin
            @(negedge Clock);
            guard++;
        end
        if (!ReqReady) begin
            n_total++;
            $display("FAIL req_accept: ReqReady still 0 after %0d cycles, expected 1", guard);
            ReqValid = 1'b0; e0 = -1000; chain_valid = 1'b0;
            return;
        end
        @(posedge Clock); #1;
        e0 = cyc;
        ReqValid = 1'b0;
        // Back-to-back bursts must be accepted on the first edge after the TURN cycle.
        if (chain_valid) chk("accept_gap", e0, next_accept);
    endtask

    task automatic write_burst(input logic [7:0] a, input int n, input int stall_at,
                               input int stall_len, input int abort_after);
        int e0;
        int guard;
        request(1'b1, a, n, e0);
        for (int i = 0; i < n; i++) begin
            logic [7:0] ai;
            ai = a + 8'(i);
            if (i == stall_at && stall_len > 0) begin
                WrValid = 1'b0;
                repeat (stall_len) @(posedge Clock);
                #1;
                if (i > 0) chk("stall_rw_hold", ReadWrite, 1);
            end
            WrData = wbuf[i]; WrValid = 1'b1;
            guard = 0;
            while (!WrReady && guard < 50) begin
                @(negedge Clock);
                guard++;
            end
            if (!WrReady) begin
                n_total++;
                $display("FAIL wr_ready: WrReady 0 for word %0d, expected 1", i);
                WrValid = 1'b0; chain_valid = 1'b0;
                return;
            end
            @(posedge Clock); #1;
            if (abort_after == i + 1) begin
                known[ai] = 1'b0;
                WrValid = 1'b0;
                ram_oe = 1'b0;
                Reset = 1'b0;
                #1;
                chk("rst_readwrite", ReadWrite, 0);
                chk("rst_data_z", Data, 8'hzz);
                chk("rst_busy", Busy, 0);
                chk("rst_reqready", ReqReady, 1);
                chk("rst_wrready", WrReady, 0);
                ram_oe = 1'b1;
                repeat (2) @(negedge Clock);
                Reset = 1'b1;
                chain_valid = 1'b0;
                return;
            end
            ref_mem[ai] = wbuf[i];
            known[ai] = 1'b1;
        end
        WrValid = 1'b0;
        next_accept = e0 + n + 3 + ((stall_at < n) ? stall_len : 0);
        chain_valid = 1'b1;
    endtask

    task automatic read_burst(input logic [7:0] a, input int n);
        int e0;
        request(1'b0, a, n, e0);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            logic [7:0] ai;
            ai = a + 8'(i);
            e.data = ref_mem[ai];
            e.care = known[ai];
            e.cyc  = e0 + 2 + i;
            sbq.push_back(e);
        end
        next_accept = e0 + n + 3;
        chain_valid = 1'b1;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
            known[i] = 1'b1;
        end

        repeat (3) @(negedge Clock);
        chk("reset_reqready", ReqReady, 1);
        chk("reset_wrready", WrReady, 0);
        chk("reset_rdvalid", RdValid, 0);
        chk("reset_rddata", RdData, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_address", Address, 0);
        chk("reset_readwrite", ReadWrite, 0);
        Reset = 1'b1;
        @(negedge Clock);

        // Single word write then read.
        wbuf[0] = 8'h5A;
        write_burst(8'h10, 1, 99, 0, 0);
        read_burst(8'h10, 1);

        // 16-word burst across the address wrap.
        for (int i = 0; i < 16; i++) wbuf[i] = 8'(i);
        write_burst(8'hF8, 16, 99, 0, 0);
        read_burst(8'hF8, 16);

        // Write with WrValid low for 3 cycles between words 2 and 3.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'hC0 + 8'(i);
        write_burst(8'h40, 4, 2, 3, 0);
        read_burst(8'h40, 4);

        // Request held during a read burst is taken exactly once after TURN.
        read_burst(8'h20, 8);
        read_burst(8'h30, 4);

        // Back-to-back write/read/write/read.
        for (int i = 0; i < 5; i++) wbuf[i] = 8'h60 ^ 8'(i * 7);
        write_burst(8'h60, 5, 99, 0, 0);
        read_burst(8'h60, 5);
        for (int i = 0; i < 3; i++) wbuf[i] = 8'h90 + 8'(i);
        write_burst(8'h80, 3, 99, 0, 0);
        read_burst(8'h80, 3);

        // Reset after the third word transfer of a 6-word write.
        for (int i = 0; i < 6; i++) wbuf[i] = 8'hE0 + 8'(i);
        write_burst(8'hA0, 6, 99, 0, 3);
        @(negedge Clock);
        read_burst(8'hA0, 6);

        // Randomized bursts.
        for (int k = 0; k < 30; k++) begin
            logic [7:0] a;
            int n;
            a = 8'($urandom);
            n = $urandom_range(1, 16);
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 16; j++) wbuf[j] = 8'($urandom);
                write_burst(a, n, $urandom_range(0, n + 3), $urandom_range(1, 3), 0);
            end else begin
                read_burst(a, n);
            end
        end

        guard = 0;
        while (sbq.size() > 0 && guard < 100) begin
            @(negedge Clock);
            guard++;
        end
        repeat (4) @(negedge Clock);
        chk("sb_drained", sbq.size(), 0);
        chk("data_never_x", x_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ram_master.md
# ram_master

Bus initiator for the shared single-port synth RAM. It accepts read or write burst requests from synth logic over a valid/ready handshake and drives the RAM's Address, ReadWrite and bidirectional Data lines. It streams write words in and read words out at one word per clock, and inserts a turnaround cycle whenever Data bus ownership changes.

## Interface
- ADDR_WIDTH, 8, RAM address width; addresses wrap modulo 2**ADDR_WIDTH
- DATA_WIDTH, 8, RAM word width
- LEN_WIDTH, 4, burst length field width; a burst moves ReqLength+1 words (1..16)

Ports:
- Clock  in  1  single clock; all state changes on posedge
- Reset  in  1  asynchronous, active-low; all state cleared immediately while low
- ReqValid  in  1  request present
- ReqReady  out  1  high only in IDLE; request accepted on a posedge with ReqValid&&ReqReady
- ReqWrite  in  1  1 = write burst, 0 = read burst
- ReqAddress  in  ADDR_WIDTH  first word address
- ReqLength  in  LEN_WIDTH  words minus one
- WrData  in  DATA_WIDTH  write word
- WrValid  in  1  write word present
- WrReady  out  1  high in WR while words remain; a word transfers on posedge with WrValid&&WrReady
- RdData  out  DATA_WIDTH  read word, registered
- RdValid  out  1  one-cycle strobe per read word; no backpressure
- Busy  out  1  high in every state except IDLE
- Address  out  ADDR_WIDTH  to RAM, registered
- Data  inout  DATA_WIDTH  shared bus; driven by master only while ReadWrite==1, else high-Z
- ReadWrite  out  1  to RAM, registered; 1 = RAM writes Data at posedge, 0 = RAM drives Data with last read word

## Operation
- States: IDLE, RD, RD_LAST, WR, TURN.
- Reset values: ReqReady=1, WrReady=0, RdValid=0, RdData=0, Busy=0, Address=0, ReadWrite=0, Data high-Z, state IDLE. Word and address counters are 0.
- IDLE: ReadWrite=0. On accept, the master latches the address and count, then goes to RD or WR.
- RD: each cycle presents Address=current address and increments it. After the last address is issued, goes to RD_LAST.
- RD_LAST: performs the final capture, then goes to TURN.
- Read capture: the RAM registers Memory[A] one edge after A is presented. The master samples Data one edge later, so the capture is pipelined at one word per cycle.
- WR: on each WrValid&&WrReady edge, the master registers Address=current address, drives Data=WrData and ReadWrite=1 for the next cycle, then increments the address and decrements the count.
- WR stall: while WrValid is low, Address, Data and ReadWrite hold. The RAM rewrites the same word, which is idempotent. Before the first word arrives, ReadWrite stays 0.
- WR exit: after the last word has been written (one edge after its transfer), ReadWrite drops to 0 and the state goes to TURN.
- TURN: one cycle with ReadWrite=0, no new request accepted, and the master not driving Data. Then returns to IDLE.
- Address arithmetic: ADDR_WIDTH bits, wraps (0xFF+1 = 0x00). The count is LEN_WIDTH+1 bits, so no overflow occurs.
- Requests presented while Busy are ignored (ReqReady=0) and must be held by the requester.
- Reset during any state aborts the burst immediately:
  - ReadWrite=0 and Data is released asynchronously.
  - No further RdValid.
  - A write word partially issued may or may not land in RAM.

## Timing
- Read latency: accept at edge E0, Address=A valid after E0, RAM latches at E1, master captures at E2. RdValid is high during the cycle after E2.
- An N-word read gives RdValid for N consecutive cycles, starting 2 cycles after the accept edge.
- Read burst occupancy: N + 3 cycles from accept back to ReqReady=1 (RD N cycles, RD_LAST 1, TURN 1, IDLE re-entry).
- Write: with WrValid held high, words land at edges E0+2 .. E0+N+1; back in IDLE after E0+N+3.
- Minimum gap between consecutive bursts is the single TURN cycle. No cycle ever has both master and RAM driving Data.

## Test plan
- Reset: hold Reset low mid-write burst -> ReadWrite=0, Data=Z, Busy=0, ReqReady=1 immediately; after release, a read shows only completed words.
- Single write then read: write 0x5A to 0x10 (len 0), then read 0x10 -> RdValid one cycle, RdData=0x5A, exactly 2 cycles after the read accept edge.
- Burst wrap: write 16 words 0x00..0x0F at 0xF8, then read back a 16-word burst -> addresses 0xF8..0xFF,0x00..0x07 return in order, with RdValid contiguous for 16 cycles.
- Write stall: a 4-word write with WrValid low for 3 cycles between words 2 and 3 -> no extra or corrupted words; readback matches.
- Busy rejection: ReqValid held during a read burst -> ReqReady=0 until the cycle after TURN; the queued request is then accepted once.
- Bus contention check: back-to-back write/read/write bursts -> Data never shows X; the TURN cycle appears between each pair of bursts.
